// File: rtl/fabric_scan_chain_ctrl_pkg.sv
// Shared types and helpers for the fabric scan-chain controller.
`timescale 1ns/1ps
package fabric_scan_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } scan_state_e;

  // Counter must be able to represent CHAIN_LEN itself.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/fabric_scan_chain_ctrl_shift_reg.sv
// Parallel-load shift register; shifts right with serial_in entering at the MSB.
`timescale 1ns/1ps
module scan_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Load has priority over shift; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= {WIDTH{1'b0}};
    end else if (load) begin
      q_r <= load_data;
    end else if (shift) begin
      q_r <= {serial_in, q_r[WIDTH-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fabric_scan_chain_ctrl.sv
// Scan controller for a chain of ff_phy tiles: serial load, optional capture,
// serial unload, and a held parallel result with valid/ready handshake.
`timescale 1ns/1ps
module fabric_scan_chain_ctrl
  import fabric_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 clk,
  input  logic                 global_resetn,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic [CHAIN_LEN-1:0] pattern,
  output logic                 scan_en,
  output logic                 scan_mode,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 busy,
  output logic [CHAIN_LEN-1:0] result_data,
  output logic                 result_valid,
  input  logic                 result_ready
);

  localparam int               CNT_W    = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_e          state_r;
  scan_state_e          state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 cap_en_r;
  logic                 scan_en_r;
  logic                 scan_mode_r;
  logic                 busy_r;
  logic                 result_valid_r;
  logic [CHAIN_LEN-1:0] result_data_r;
  logic                 scan_en_s;
  logic                 scan_mode_s;
  logic                 busy_s;
  logic                 load_s;
  logic                 shifting_s;
  logic                 last_s;
  logic [CHAIN_LEN-1:0] pat_q_s;
  logic [CHAIN_LEN-1:0] cap_q_s;
  logic                 unused_pat_s;

  assign load_s     = (state_r == IDLE) && start;
  assign shifting_s = (state_r == SHIFT) || (state_r == UNLOAD);
  assign last_s     = (cnt_r == CNT_LAST);

  // The pattern register drains to zero while shifting, so its LSB is
  // already 0 in CAPTURE/UNLOAD/DONE and can drive scan_si directly.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_pat_reg (
    .clk       (clk),
    .rst_n     (global_resetn),
    .load      (load_s),
    .shift     (state_r == SHIFT),
    .load_data (pattern),
    .serial_in (1'b0),
    .q         (pat_q_s)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_cap_reg (
    .clk       (clk),
    .rst_n     (global_resetn),
    .load      (1'b0),
    .shift     (shifting_s),
    .load_data ({CHAIN_LEN{1'b0}}),
    .serial_in (scan_so),
    .q         (cap_q_s)
  );

  assign unused_pat_s = ^pat_q_s[CHAIN_LEN-1:1];

  // Next-state and next-cycle output decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SHIFT;
        else       state_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_s = cap_en_r ? CAPTURE : DONE;
        else        state_s = SHIFT;
      end
      CAPTURE: state_s = UNLOAD;
      UNLOAD: begin
        if (last_s) state_s = DONE;
        else        state_s = UNLOAD;
      end
      DONE: begin
        if (result_valid_r && result_ready) state_s = IDLE;
        else                                state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
    scan_en_s   = (state_s == SHIFT) || (state_s == UNLOAD);
    scan_mode_s = (state_s == SHIFT) || (state_s == CAPTURE) || (state_s == UNLOAD);
    busy_s      = (state_s != IDLE);
  end

  // State, counter, registered outputs and result holding.
  always_ff @(posedge clk) begin
    if (!global_resetn) begin
      state_r        <= IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      cap_en_r       <= 1'b0;
      scan_en_r      <= 1'b0;
      scan_mode_r    <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      result_data_r  <= {CHAIN_LEN{1'b0}};
    end else begin
      state_r     <= state_s;
      scan_en_r   <= scan_en_s;
      scan_mode_r <= scan_mode_s;
      busy_r      <= busy_s;
      if (load_s) begin
        cap_en_r <= capture_en;
      end else begin
        cap_en_r <= cap_en_r;
      end
      if (load_s || (state_r == CAPTURE)) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (shifting_s) begin
        cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      // The capture register is complete on entry to DONE; publish it with valid.
      if ((state_r == DONE) && !result_valid_r) begin
        result_valid_r <= 1'b1;
        result_data_r  <= cap_q_s;
      end else if ((state_r == DONE) && result_ready) begin
        result_valid_r <= 1'b0;
        result_data_r  <= result_data_r;
      end else begin
        result_valid_r <= result_valid_r;
        result_data_r  <= result_data_r;
      end
    end
  end

  assign scan_en      = scan_en_r;
  assign scan_mode    = scan_mode_r;
  assign scan_si      = pat_q_s[0];
  assign busy         = busy_r;
  assign result_valid = result_valid_r;
  assign result_data  = result_data_r;

endmodule

// File: tb/tb_fabric_scan_chain_ctrl.sv
// Self-checking bench: behavioural ff_phy chains around an 8-bit and a 2-bit
// controller, randomized sequences checked against a result-level model.
`timescale 1ns/1ps
module tb_fabric_scan_chain_ctrl;

  localparam int N  = 8;
  localparam int N2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          global_resetn, start, capture_en, scan_en, scan_mode, scan_si, scan_so;
  logic          busy, result_valid, result_ready;
  logic [N-1:0]  pattern, result_data, chain, d_in;
  logic          start_b, scan_en_b, scan_mode_b, scan_si_b, scan_so_b, busy_b;
  logic          result_valid_b, result_ready_b;
  logic [N2-1:0] pattern_b, result_data_b, chain_b;

  fabric_scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk(clk), .global_resetn(global_resetn), .start(start), .capture_en(capture_en),
    .pattern(pattern), .scan_en(scan_en), .scan_mode(scan_mode), .scan_si(scan_si),
    .scan_so(scan_so), .busy(busy), .result_data(result_data),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  fabric_scan_chain_ctrl #(.CHAIN_LEN(N2)) dut_b (
    .clk(clk), .global_resetn(global_resetn), .start(start_b), .capture_en(1'b0),
    .pattern(pattern_b), .scan_en(scan_en_b), .scan_mode(scan_mode_b), .scan_si(scan_si_b),
    .scan_so(scan_so_b), .busy(busy_b), .result_data(result_data_b),
    .result_valid(result_valid_b), .result_ready(result_ready_b)
  );

  // Behavioural ff_phy chains: bit 0 is the tail, SI enters at the head.
  initial begin
    chain   = '0;
    chain_b = '0;
  end
  always @(posedge clk) begin
    if (scan_en)        chain <= {scan_si, chain[N-1:1]};
    else if (scan_mode) chain <= d_in;
    if (scan_en_b)        chain_b <= {scan_si_b, chain_b[N2-1:1]};
    else if (scan_mode_b) chain_b <= '0;
  end
  assign scan_so   = chain[0];
  assign scan_so_b = chain_b[0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result-level model: the chain holds the last loaded pattern, or zeros after a capture run.
  logic [N-1:0] model_chain = '0;
  bit           model_known = 1'b1;

  task automatic run_seq(input logic [N-1:0] pat, input bit cap, input int hold);
    int k, en_cnt, capcyc;
    logic [N-1:0] si_word, exp_res, held;
    logic si_tail;
    exp_res = cap ? d_in : model_chain;
    @(negedge clk);
    pattern = pat; capture_en = cap; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pattern = N'($urandom); capture_en = 1'($urandom);
    en_cnt = 0; capcyc = 0; si_word = '0; si_tail = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (result_valid) break;
      if (scan_en) begin
        if (en_cnt < N) si_word[en_cnt] = scan_si;
        else            si_tail = si_tail | scan_si;
        en_cnt++;
      end
      if (!scan_en && scan_mode) capcyc++;
      @(posedge clk); #1;
    end
    check_val("latency", k, cap ? 2*N+2 : N+1);
    check_val("scan_en_cycles", en_cnt, cap ? 2*N : N);
    check_val("capture_cycles", capcyc, {31'd0, cap});
    check_val("scan_si_seq", si_word, pat);
    check_val("unload_si_zero", si_tail, 0);
    check_val("done_mode_off", {scan_en, scan_mode}, 0);
    if (cap || model_known) check_val("result_data", result_data, exp_res);
    if (cap) check_val("chain_zero", chain, 0);
    model_chain = cap ? '0 : pat;
    model_known = 1'b1;
    held = result_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = (i == hold/2); pattern = N'($urandom);
      @(posedge clk); #1;
      check_val("bp_valid", result_valid, 1);
      check_val("bp_data", result_data, held);
      check_val("bp_busy", busy, 1);
    end
    @(negedge clk);
    start = 1'b0; result_ready = 1'b1;
    @(posedge clk); #1;
    check_val("hs_valid_clear", result_valid, 0);
    check_val("hs_idle", busy, 0);
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic run_b(input logic [N2-1:0] pat, input logic [N2-1:0] exp_res);
    int k, en_cnt;
    logic [N2-1:0] si_word;
    @(negedge clk);
    pattern_b = pat; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0; en_cnt = 0; si_word = '0;
    for (k = 0; k < 50; k++) begin
      if (result_valid_b) break;
      if (scan_en_b) begin
        if (en_cnt < N2) si_word[en_cnt] = scan_si_b;
        en_cnt++;
      end
      @(posedge clk); #1;
    end
    check_val("b_latency", k, N2+1);
    check_val("b_si_seq", si_word, pat);
    check_val("b_result", result_data_b, exp_res);
    @(negedge clk);
    result_ready_b = 1'b1;
    @(posedge clk); #1;
    check_val("b_hs", {result_valid_b, busy_b}, 0);
    @(negedge clk);
    result_ready_b = 1'b0;
  endtask

  initial begin
    bit seen;
    global_resetn = 1'b0; start = 1'b1; start_b = 1'b1; capture_en = 1'b0;
    pattern = 8'hFF; pattern_b = 2'b11; result_ready = 1'b0; result_ready_b = 1'b0;
    d_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("rst_outputs", {scan_en, scan_mode, scan_si, busy, result_valid}, 0);
      check_val("rst_data", result_data, 0);
      check_val("rst_b", {scan_en_b, scan_mode_b, busy_b, result_valid_b}, 0);
    end
    @(negedge clk);
    start = 1'b0; start_b = 1'b0; global_resetn = 1'b1;

    run_seq(8'hA5, 1'b0, 0);
    run_seq(8'h3C, 1'b0, 10);
    d_in = 8'h5A;
    run_seq(8'hFF, 1'b1, 3);
    for (int r = 0; r < 6; r++) begin
      d_in = N'($urandom);
      run_seq(N'($urandom), 1'($urandom), $urandom_range(0, 4));
    end

    // Abort in UNLOAD at cnt==3: that is the state after start edge + N + 4.
    @(negedge clk);
    pattern = N'($urandom); capture_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;
    check_val("abort_in_unload", {scan_en, scan_mode, busy}, 3'b111);
    @(negedge clk);
    global_resetn = 1'b0;
    @(posedge clk); #1;
    check_val("abort_outputs", {scan_en, scan_mode, busy, result_valid}, 0);
    @(negedge clk);
    global_resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2*N+4; i++) begin
      @(posedge clk); #1;
      seen = seen | result_valid | busy;
    end
    check_val("abort_quiet", seen, 0);
    model_known = 1'b0;
    d_in = N'($urandom);
    run_seq(N'($urandom), 1'b1, 1);
    run_seq(N'($urandom), 1'b0, 0);

    run_b(2'b01, 2'b00);
    run_b(2'b10, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
